// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared FSM state type and default width for serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : 1-bit combinational full adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder (LSB first, one full-adder cell); optional
//               subtract mode enabled by macro SERIAL_ADDER_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_CNT_W = $clog2(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sub;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_sub;
    logic w_b_bit;
    logic w_s;
    logic w_co;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // Subtraction is a + ~b + 1: invert b bit-wise and seed the carry with 1.
    assign w_b_bit = r_b[0] ^ r_sub;

    full_adder u_fa (
        .a    (r_a[0]),
        .b    (w_b_bit),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_co)
    );

    // Result bits shift into the top of r_a as operand bits leave the bottom,
    // so after WIDTH steps r_a holds the complete result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sub   <= w_sub;
                        r_carry <= w_sub;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a     <= {w_s, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(WIDTH - 1)) begin
                        sum     <= {w_s, r_a[WIDTH-1:1]};
                        cout    <= r_sub ? ~w_co : w_co;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted op shows busy for W+1 cycles, then a one
    // cycle done pulse; result is plain arithmetic on captured operands.
    int           m_t = -1;
    logic [W-1:0] m_a, m_b;
    logic         m_sub;
    logic         e_busy = 1'b0, e_done = 1'b0, e_cout = 1'b0;
    logic [W-1:0] e_sum = '0;
    logic [W:0]   m_full;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_t = -1; e_busy = 0; e_done = 0; e_sum = '0; e_cout = 0;
        end else begin
            e_done = 0;
            if (m_t < 0) begin
                if (start) begin
                    m_t = 0; m_a = a; m_b = b; e_busy = 1;
`ifdef SERIAL_ADDER_SUB_EN
                    m_sub = sub;
`else
                    m_sub = 1'b0;
`endif
                end
            end else begin
                m_t++;
                if (m_t == W) begin
                    if (m_sub) begin
                        e_sum  = m_a - m_b;
                        e_cout = (m_a < m_b);
                    end else begin
                        m_full = {1'b0, m_a} + {1'b0, m_b};
                        e_sum  = m_full[W-1:0];
                        e_cout = m_full[W];
                    end
                end else if (m_t == W + 1) begin
                    e_done = 1; e_busy = 0; m_t = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("done", {31'd0, done}, {31'd0, e_done});
            chk("sum",  {24'd0, sum},  {24'd0, e_sum});
            chk("cout", {31'd0, cout}, {31'd0, e_cout});
        end
    end

    // Drives one op, scrambles operands after acceptance, waits for done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, output int lat, output int bcnt);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_v; sub = ~ts;
        lat = 1; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int lat, bcnt, ndone, first_done, last_done;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum",  {24'd0, sum},  32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_op(8'h3C, 8'h05, 1'b0, lat, bcnt);
        chk("lat_3c05", lat, 10);
        chk("busy_cycles", bcnt, 9);
        chk("sum_3c05", {24'd0, sum}, 32'h41);
        chk("cout_3c05", {31'd0, cout}, 32'd0);

        run_op(8'hFF, 8'h01, 1'b0, lat, bcnt);
        chk("sum_ff01", {24'd0, sum}, 32'h00);
        chk("cout_ff01", {31'd0, cout}, 32'd1);

        run_op(8'hA5, 8'h5A, 1'b0, lat, bcnt);
        chk("sum_a55a", {24'd0, sum}, 32'hFF);
        chk("cout_a55a", {31'd0, cout}, 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, lat, bcnt);
        chk("sum_sub0507", {24'd0, sum}, 32'hFE);
        chk("cout_sub0507", {31'd0, cout}, 32'd1);
        run_op(8'h07, 8'h05, 1'b1, lat, bcnt);
        chk("sum_sub0705", {24'd0, sum}, 32'h02);
        chk("cout_sub0705", {31'd0, cout}, 32'd0);
        run_op(8'h33, 8'h33, 1'b1, lat, bcnt);
        chk("sum_sub3333", {24'd0, sum}, 32'h00);
        chk("cout_sub3333", {31'd0, cout}, 32'd0);
`endif

        // Abort mid-run with reset; no done may follow.
        @(negedge clk);
        a = 8'h80; b = 8'h80; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum",  {24'd0, sum},  32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        run_op(8'h80, 8'h80, 1'b0, lat, bcnt);
        chk("sum_after_abort", {24'd0, sum}, 32'h00);
        chk("cout_after_abort", {31'd0, cout}, 32'd1);

        // Continuous start with operands changing every cycle.
        @(negedge clk);
        start = 1'b1; sub = 1'b0;
        ndone = 0; first_done = -1; last_done = -1;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom); b = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub = 1'($urandom);
`endif
            @(negedge clk);
            if (done) begin
                if (ndone > 0) chk("b2b_period", i - last_done, 10);
                if (ndone == 0) first_done = i;
                ndone++;
                last_done = i;
            end
        end
        start = 1'b0;
        chk("b2b_count", ndone, 3);
        chk("b2b_first", first_done, 9);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            run_op(W'($urandom), W'($urandom), 1'($urandom), lat, bcnt);
`else
            run_op(W'($urandom), W'($urandom), 1'b0, lat, bcnt);
`endif
            chk("rand_lat", lat, 10);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
